// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// It shows a double-buffered 16-bit hex value one digit at a time, with a
// blank guard gap between digits. It also provides leading-zero blanking,
// per-digit decimal points and a tear-free valid/ready load port.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 25000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  input  logic        lz_en,
  output logic [3:0]  hex_out,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SCAN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      front_q;
  logic [3:0]       front_dp_q;
  logic [15:0]      stage_q;
  logic [3:0]       stage_dp_q;
  logic             staged_full_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic             frame_tick_q;

  logic [1:0]       hex_sel;
  logic             xfer;
  logic             update_edge;
  logic             blank_next;

  // Leading-zero blanking: a digit goes dark when it and every digit to its
  // left are zero; digit 0 always shows so the display never goes empty.
  function automatic logic digit_blank(input logic [15:0] v, input logic [1:0] i,
                                       input logic en);
    logic b;
    case (i)
      2'd3:    b = (v[15:12] == 4'h0);
      2'd2:    b = (v[15:8]  == 8'h00);
      2'd1:    b = (v[15:4]  == 12'h000);
      default: b = 1'b0;
    endcase
    return b & en;
  endfunction

  // In GUARD the decoder is pre-fed the upcoming digit so its pattern can be
  // registered on the GUARD->SCAN edge; in SCAN it follows the lit digit.
  assign hex_sel     = (state_q == ST_GUARD) ? (idx_q + 2'd1) : idx_q;
  assign hex_out     = front_q[{hex_sel, 2'b00} +: 4];
  assign load_ready  = ~staged_full_q;
  assign xfer        = load_valid & ~staged_full_q;
  assign update_edge = (state_q == ST_SCAN) && (cnt_q == SCAN_LAST) && (idx_q == 2'd3);
  assign blank_next  = digit_blank(front_q, hex_sel, lz_en);

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

  // Scan FSM, staging/front double buffer and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_GUARD;
      idx_q         <= 2'd3;
      cnt_q         <= '0;
      front_q       <= 16'h0000;
      front_dp_q    <= 4'h0;
      stage_q       <= 16'h0000;
      stage_dp_q    <= 4'h0;
      staged_full_q <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;

      if (xfer) begin
        stage_q    <= load_data;
        stage_dp_q <= load_dp;
      end

      // A transfer cannot coincide with a full slot, so clear and set never collide.
      if (update_edge && staged_full_q) begin
        staged_full_q <= 1'b0;
      end else if (xfer) begin
        staged_full_q <= 1'b1;
      end

      case (state_q)
        ST_SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            state_q <= ST_GUARD;
            cnt_q   <= '0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            if (idx_q == 2'd3) begin
              frame_tick_q <= 1'b1;
              if (staged_full_q) begin
                front_q    <= stage_q;
                front_dp_q <= stage_dp_q;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_q <= ST_SCAN;
            idx_q   <= hex_sel;
            cnt_q   <= '0;
            an_q    <= ~(4'b0001 << hex_sel);
            seg_q   <= blank_next ? 7'h7F : seg_in;
            dp_q    <= ~front_dp_q[hex_sel];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_GUARD;
          cnt_q   <= '0;
          an_q    <= 4'hF;
          seg_q   <= 7'h7F;
          dp_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
